// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator: FSM encoding, default
// timing constants and the width-step computation.
package servo_pkg;

   // Period phases: idle, pulse high, pulse low until period end.
   typedef enum logic [1:0] {
      INATIVO = 2'd0,
      PULSO   = 2'd1,
      ESPERA  = 2'd2
   } estado_t;

   // Defaults: 20 ms period, 1 ms .. 2 ms pulse at 50 MHz, 50 positions.
   localparam int unsigned PERIODO_PADRAO     = 1000000;
   localparam int unsigned LARGURA_MIN_PADRAO = 50000;
   localparam int unsigned LARGURA_MAX_PADRAO = 100000;
   localparam int unsigned M_PADRAO           = 50;
   localparam int unsigned N_PADRAO           = 6;

   // Clocks added to the pulse per position step; truncated, so the top
   // position may fall slightly short of the nominal maximum width.
   function automatic int unsigned calc_passo(input int unsigned largura_min,
                                              input int unsigned largura_max,
                                              input int unsigned m);
      return (largura_max - largura_min) / (m - 1);
   endfunction

endpackage

// File: rtl/servo_pwm_posicao_contador_periodo.sv
// Modulo-PERIODO cycle counter with synchronous clear and count enable.
// Exposes the count and a flag marking the last count of the period.
module contador_periodo
   import servo_pkg::*;
#(
   parameter int unsigned PERIODO = PERIODO_PADRAO,
   parameter int unsigned W       = $clog2(PERIODO)
) (
   input  logic         clock,
   input  logic         zera_s_n,
   input  logic         limpa,
   input  logic         habilita,
   output logic [W-1:0] cnt,
   output logic         ultimo
);

   localparam logic [W-1:0] CNT_ULTIMO = W'(PERIODO - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise wrap at the last count.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (limpa) begin
         cnt_d = '0;
      end else if (habilita) begin
         cnt_d = (cnt_q == CNT_ULTIMO) ? '0 : cnt_q + W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: reset is tested inside the clocked block, so it only acts on an edge; non-blocking keeps all flops sampling pre-edge values.
      if (!zera_s_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign ultimo = (cnt_q == CNT_ULTIMO);

endmodule

// File: rtl/servo_pwm_posicao.sv
// Servo PWM generator: converts a position index into a fixed-period pulse
// whose width is linear in position. A new position is taken only at a
// period boundary, so every pulse is complete and undistorted.
module servo_pwm_posicao
   import servo_pkg::*;
#(
   parameter int unsigned PERIODO     = PERIODO_PADRAO,
   parameter int unsigned LARGURA_MIN = LARGURA_MIN_PADRAO,
   parameter int unsigned LARGURA_MAX = LARGURA_MAX_PADRAO,
   parameter int unsigned M           = M_PADRAO,
   parameter int unsigned N           = N_PADRAO
) (
   input  logic         clock,
   input  logic         zera_s_n,
   input  logic         liga,
   input  logic [N-1:0] posicao,
   output logic         pwm,
   output logic         fim_periodo,
   output logic [N-1:0] posicao_atual,
   output logic         ativo
);

   localparam int unsigned W     = $clog2(PERIODO);
   localparam int unsigned WL    = W + N;
   localparam int unsigned PASSO = calc_passo(LARGURA_MIN, LARGURA_MAX, M);

   estado_t      estado_q, estado_d;
   logic [W-1:0] largura_q, largura_d;
   logic [N-1:0] posicao_atual_q, posicao_atual_d;

   logic [N-1:0] p_clamp;
   logic [W-1:0] largura_nova;
   logic [W-1:0] cnt;
   logic         ultimo;
   logic         limpa;
   logic         habilita;

   contador_periodo #(
      .PERIODO (PERIODO),
      .W       (W)
   ) u_contador (
      .clock    (clock),
      .zera_s_n (zera_s_n),
      .limpa    (limpa),
      .habilita (habilita),
      .cnt      (cnt),
      .ultimo   (ultimo)
   );

   // Clamp the requested position and derive its pulse width. The product
   // is formed at W+N bits; the final sum never exceeds LARGURA_MAX < PERIODO.
   always_comb begin
      p_clamp = posicao;
      if ({1'b0, posicao} >= (N+1)'(M)) begin
         p_clamp = N'(M - 1);
      end
      largura_nova = W'(LARGURA_MIN) + W'(WL'(p_clamp) * WL'(PASSO));
   end

   // FSM next state, period-boundary latching and counter control.
   always_comb begin
      estado_d        = estado_q;
      largura_d       = largura_q;
      posicao_atual_d = posicao_atual_q;
      limpa           = 1'b0;
      habilita        = 1'b0;
      unique case (estado_q)
         INATIVO: begin
            limpa = 1'b1;
            if (liga) begin
               estado_d        = PULSO;
               largura_d       = largura_nova;
               posicao_atual_d = p_clamp;
            end
         end
         PULSO: begin
            habilita = 1'b1;
            if (cnt == largura_q - W'(1)) begin
               estado_d = ESPERA;
            end
         end
         ESPERA: begin
            // The counter wraps to 0 here on its own, giving back-to-back
            // periods with no gap cycle.
            habilita = 1'b1;
            if (ultimo) begin
               if (liga) begin
                  estado_d        = PULSO;
                  largura_d       = largura_nova;
                  posicao_atual_d = p_clamp;
               end else begin
                  estado_d = INATIVO;
               end
            end
         end
         default: begin
            estado_d = INATIVO;
         end
      endcase
   end

   // State, latched width and latched position registers.
   always_ff @(posedge clock) begin
      if (!zera_s_n) begin
         estado_q        <= INATIVO;
         largura_q       <= W'(LARGURA_MIN);
         posicao_atual_q <= '0;
      end else begin
         estado_q        <= estado_d;
         largura_q       <= largura_d;
         posicao_atual_q <= posicao_atual_d;
      end
   end

   // Moore outputs decoded from registered state and count only.
   always_comb begin
      pwm         = (estado_q == PULSO);
      ativo       = (estado_q != INATIVO);
      fim_periodo = (estado_q == ESPERA) && ultimo;
   end

   assign posicao_atual = posicao_atual_q;

endmodule

// File: doc/servo_pwm_posicao.md
Name: servo_pwm_posicao

Overview:
Downstream consumer of the sweep up/down position counter (Q, 0..M-1). Converts the position index into a servo PWM waveform with a fixed period and a pulse width linear in position. Samples a new position only at period boundaries, so the servo never sees a truncated or stretched pulse. Emits a one-cycle end-of-period tick that can drive the counter's `conta` input.

Parameters:
PERIODO, 1000000, clocks per PWM period (20 ms at 50 MHz)
LARGURA_MIN, 50000, pulse width in clocks for position 0 (1 ms)
LARGURA_MAX, 100000, nominal pulse width for position M-1 (2 ms)
M, 50, number of positions; must match the upstream counter modulus
N, 6, position width in bits
Constraints: M>=2; LARGURA_MIN < LARGURA_MAX < PERIODO

Ports:
clock  in  1  single system clock, rising edge
zera_s_n  in  1  reset, synchronous, active-low
liga  in  1  enable; level-sensitive
posicao  in  N  requested position (the counter's Q)
pwm  out  1  servo PWM output
fim_periodo  out  1  one-cycle pulse on the last clock of each active period
posicao_atual  out  N  position latched for the current period (after clamp)
ativo  out  1  high while a period is in progress

Behaviour:
- All state is updated on the rising edge of `clock`. `zera_s_n`=0 at an edge overrides everything else.
- Reset values:
  - state=INATIVO, cnt=0, largura=LARGURA_MIN, posicao_atual=0
  - pwm=0, fim_periodo=0, ativo=0
- Width arithmetic:
  - PASSO = (LARGURA_MAX-LARGURA_MIN)/(M-1), integer, truncated.
  - largura = LARGURA_MIN + p*PASSO.
  - p = posicao clamped to M-1 when posicao >= M.
  - Defaults give PASSO=1020 and a position-49 width of 99980.
  - cnt width is $clog2(PERIODO). The product is sized so it cannot overflow.
- States:
  - INATIVO: pwm=0, ativo=0. If liga=1 at an edge: go to PULSO, cnt<=0, latch p into posicao_atual, latch largura.
  - PULSO: pwm=1, cnt increments. When cnt==largura-1: go to ESPERA, cnt increments.
  - ESPERA: pwm=0, cnt increments. When cnt==PERIODO-1, fim_periodo=1 for that cycle. At that edge:
    - liga=1: go to PULSO, cnt<=0, latch new p and largura. Back-to-back periods with no gap cycle.
    - liga=0: go to INATIVO.
- pwm and fim_periodo are decoded from registered state/cnt only (Moore); they are glitch-free.
- Latency: liga seen at edge k gives pwm=1 from cycle k+1. pwm high exactly largura cycles; period exactly PERIODO cycles.
- ativo=1 in PULSO and ESPERA.
- posicao changes mid-period are ignored until the next boundary.
- liga falling mid-period: the current period completes in full, including fim_periodo; then INATIVO.
- Reset mid-pulse: pwm=0 the cycle after the reset edge; no remaining pulse.
- Holding posicao out of range is not an error; it is clamped.

Decomposition:
- Shared package servo_pkg holds:
  - state encoding (INATIVO, PULSO, ESPERA)
  - default timing constants
  - the PASSO computation as a constant function
- One natural sub-module, contador_periodo: a modulo-PERIODO counter with sync clear and enable, exposing cnt and the last-count flag. The FSM, clamp and width datapath stay in the top.

Test Plan:
Use small parameters: PERIODO=100, LARGURA_MIN=10, LARGURA_MAX=20, M=6, N=3, giving PASSO=2.
1. Reset, liga=1, posicao=0 -> pwm high 10 cycles starting the cycle after liga is sampled, low 90 cycles; fim_periodo pulses once at cycle 100; ativo=1 throughout.
2. posicao=5 -> pwm high 20 cycles; posicao=3 -> 16 cycles; posicao=7 (out of range) -> clamped to 5, posicao_atual=5, 20 cycles.
3. posicao changes 0->5 at cycle 4 of a period -> current pulse stays 10 cycles; next period is 20 cycles; no gap between periods.
4. liga drops at cycle 5 (mid-pulse) -> pulse completes 10 cycles, fim_periodo at cycle 100, then pwm=0 and ativo=0 indefinitely.
5. zera_s_n=0 at cycle 6 of a pulse -> next cycle pwm=0, ativo=0, posicao_atual=0; with liga still 1 after release, a fresh full period starts one cycle later.
6. Loop fim_periodo into an up/down counter (M=6) conta input -> posicao_atual sequence 0,1,2,3,4,5,4,3,2,1,0,1 with widths 10,12,14,16,18,20,18,...
